ila_capture_ctrl: RTL and testbench

Capture sequencer for the ILA sampling core. It arms, clears and enables the core, evaluates a masked value-match trigger on the probed signal, counts post-trigger samples and stops capture. It reports completion and the buffer index of the trigger sample. It sits between the ILA software register file and ila_core; all logic runs on the single system clock, and a one-cycle sample_en strobe qualifies each sample.

---
 rtl/ila_ctrl_pkg.sv | 13 +
 rtl/ila_trig_match.sv | 28 ++
 rtl/ila_capture_ctrl.sv | 149 ++++++++++++++
 tb/tb_ila_capture_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ila_ctrl_pkg.sv
// ila_ctrl_pkg: shared state encodings and default widths for the ILA capture controller.
package ila_ctrl_pkg;
    localparam int STATE_W = 3;
    localparam int DATA_W_DEF = 32;
    localparam int BUFFER_W_DEF = 10;
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } state_e;
endpackage

// File: rtl/ila_trig_match.sv
// ila_trig_match: masked level/rising value-match trigger qualified by sample_en.
module ila_trig_match
    import ila_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] signal_i,
    input  logic [DATA_W-1:0] mask_i,
    input  logic [DATA_W-1:0] value_i,
    input  logic              edge_i,
    input  logic              ext_trigger_i,
    input  logic              sample_en_i,
    input  logic              clear_i,
    output logic              hit_o
);
    logic match;
    logic prev_match_q;

    assign match = ((signal_i ^ value_i) & mask_i) == '0;
    assign hit_o = sample_en_i & ((edge_i ? (match & ~prev_match_q) : match) | ext_trigger_i);

    always_ff @(posedge clk_i) begin
        if (!rst_i || clear_i) prev_match_q <= 1'b0;
        else if (sample_en_i) prev_match_q <= match;
    end
endmodule

// File: rtl/ila_capture_ctrl.sv
// ila_capture_ctrl: ILA capture sequencer (arm, clear, trigger, post-count, done).
// Optional pre-trigger holdoff via ILA_CAPTURE_HOLDOFF_EN.
module ila_capture_ctrl
    import ila_ctrl_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int BUFFER_W = BUFFER_W_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                arm_i,
    input  logic                abort_i,
    input  logic                sample_en_i,
    input  logic [DATA_W-1:0]   signal_i,
    input  logic [DATA_W-1:0]   trig_mask_i,
    input  logic [DATA_W-1:0]   trig_value_i,
    input  logic                trig_edge_i,
    input  logic                ext_trigger_i,
`ifdef ILA_CAPTURE_HOLDOFF_EN
    input  logic [BUFFER_W-1:0] pre_cnt_i,
`endif
    input  logic [BUFFER_W-1:0] post_cnt_i,
    output logic                core_enabled_o,
    output logic                core_rst_soft_o,
    output logic                trigger_out_o,
    output logic [BUFFER_W-1:0] wr_ptr_o,
    output logic [BUFFER_W-1:0] trig_index_o,
    output logic [STATE_W-1:0]  state_o,
    output logic                done_o,
    output logic                irq_o
);
    localparam logic [BUFFER_W-1:0] ONE = {{(BUFFER_W-1){1'b0}}, 1'b1};

    state_e              state_q;
    logic [BUFFER_W-1:0] wr_ptr_q, wr_ptr_d, trig_index_q, remain_q, remain_d, post_q;
    logic                edge_q, core_en_q, core_rst_q, trig_out_q, done_q, irq_q;
    logic                hit, accept;

    assign wr_ptr_d = wr_ptr_q + ONE;
    assign remain_d = remain_q - ONE;

    ila_trig_match #(.DATA_W(DATA_W)) u_match (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .signal_i      (signal_i),
        .mask_i        (trig_mask_i),
        .value_i       (trig_value_i),
        .edge_i        (edge_q),
        .ext_trigger_i (ext_trigger_i),
        .sample_en_i   (sample_en_i),
        .clear_i       (state_q == CLEAR),
        .hit_o         (hit)
    );

`ifdef ILA_CAPTURE_HOLDOFF_EN
    logic [BUFFER_W-1:0] pre_q, fill_q;
    // fill saturates, so fill >= pre means at least pre samples of history exist
    assign accept = hit & (fill_q >= pre_q);
`else
    assign accept = hit;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            trig_index_q <= '0;
            remain_q     <= '0;
            post_q       <= '0;
            edge_q       <= 1'b0;
            core_en_q    <= 1'b0;
            core_rst_q   <= 1'b0;
            trig_out_q   <= 1'b0;
            done_q       <= 1'b0;
            irq_q        <= 1'b0;
`ifdef ILA_CAPTURE_HOLDOFF_EN
            pre_q        <= '0;
            fill_q       <= '0;
`endif
        end else begin
            core_rst_q <= 1'b0;
            trig_out_q <= 1'b0;
            irq_q      <= 1'b0;
            if (abort_i) begin
                state_q   <= IDLE;
                core_en_q <= 1'b0;
                done_q    <= 1'b0;
            end else case (state_q)
                IDLE, DONE: if (arm_i) begin
                    state_q    <= CLEAR;
                    post_q     <= post_cnt_i;
                    edge_q     <= trig_edge_i;
                    wr_ptr_q   <= '0;
                    done_q     <= 1'b0;
                    core_rst_q <= 1'b1;
`ifdef ILA_CAPTURE_HOLDOFF_EN
                    pre_q      <= pre_cnt_i;
                    fill_q     <= '0;
`endif
                end
                CLEAR: begin
                    state_q   <= ARMED;
                    core_en_q <= 1'b1;
                end
                ARMED: begin
                    if (sample_en_i) wr_ptr_q <= wr_ptr_d;
`ifdef ILA_CAPTURE_HOLDOFF_EN
                    if (sample_en_i && fill_q != '1) fill_q <= fill_q + ONE;
`endif
                    if (accept) begin
                        trig_index_q <= wr_ptr_q;
                        trig_out_q   <= 1'b1;
                        remain_q     <= post_q;
                        state_q      <= (post_q == '0) ? DONE : POST;
                        if (post_q == '0) begin
                            core_en_q <= 1'b0;
                            done_q    <= 1'b1;
                            irq_q     <= 1'b1;
                        end
                    end
                end
                POST: if (sample_en_i) begin
                    wr_ptr_q <= wr_ptr_d;
                    remain_q <= remain_d;
                    if (remain_q == ONE) begin
                        state_q   <= DONE;
                        core_en_q <= 1'b0;
                        done_q    <= 1'b1;
                        irq_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    core_en_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign core_enabled_o  = core_en_q;
    assign core_rst_soft_o = core_rst_q;
    assign trigger_out_o   = trig_out_q;
    assign wr_ptr_o        = wr_ptr_q;
    assign trig_index_o    = trig_index_q;
    assign state_o         = state_q;
    assign done_o          = done_q;
    assign irq_o           = irq_q;
endmodule

// File: tb/tb_ila_capture_ctrl.sv
// tb_ila_capture_ctrl: directed bench with a per-cycle reference model for ila_capture_ctrl.
module tb_ila_capture_ctrl;
    logic        clk = 0, rst = 0, arm = 0, abort = 0, se = 0, ext = 0, tedge = 0;
    logic [31:0] sig = 0, mask = 0, value = 0;
    logic [3:0]  post = 0;
`ifdef ILA_CAPTURE_HOLDOFF_EN
    logic [3:0]  pre = 0;
`endif
    logic        core_en, core_rst, trig_out, done, irq;
    logic [3:0]  wr, ti;
    logic [2:0]  st;
    int ntests = 0, nfail = 0;
    int n_trig = 0, n_irq = 0, n_post = 0;
    int t0, i0, p0;

    int m_state = 0, m_last = 0, m_wr = 0, m_ti = 0, m_rem = 0, m_post = 0, m_pre = 0;
    logic m_edge = 0, m_prev = 0, m_trig = 0;

    always #5 clk = ~clk;

    ila_capture_ctrl #(.DATA_W(32), .BUFFER_W(4)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .arm_i           (arm),
        .abort_i         (abort),
        .sample_en_i     (se),
        .signal_i        (sig),
        .trig_mask_i     (mask),
        .trig_value_i    (value),
        .trig_edge_i     (tedge),
        .ext_trigger_i   (ext),
`ifdef ILA_CAPTURE_HOLDOFF_EN
        .pre_cnt_i       (pre),
`endif
        .post_cnt_i      (post),
        .core_enabled_o  (core_en),
        .core_rst_soft_o (core_rst),
        .trigger_out_o   (trig_out),
        .wr_ptr_o        (wr),
        .trig_index_o    (ti),
        .state_o         (st),
        .done_o          (done),
        .irq_o           (irq)
    );

    task automatic chk(input string nm, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: m_wr counts samples without wrapping; the DUT shows it mod 16
    always @(posedge clk) begin : model
        logic match, hit;
        if (!rst) begin
            m_state = 0; m_last = 0; m_wr = 0; m_ti = 0; m_rem = 0; m_post = 0; m_pre = 0;
            m_edge = 0; m_prev = 0; m_trig = 0;
        end else begin
            match = ((sig ^ value) & mask) == 0;
            hit = se && ((m_edge ? (match && !m_prev) : match) || ext);
            if (m_state == 1) m_prev = 0;
            else if (se) m_prev = match;
            m_last = m_state;
            m_trig = 0;
            if (abort) m_state = 0;
            else if ((m_state == 0 || m_state == 4) && arm) begin
                m_state = 1; m_post = post; m_edge = tedge; m_wr = 0;
`ifdef ILA_CAPTURE_HOLDOFF_EN
                m_pre = pre;
`endif
            end else if (m_state == 1) m_state = 2;
            else if (m_state == 2) begin
                if (hit && m_wr >= m_pre) begin
                    m_ti = m_wr; m_trig = 1; m_rem = m_post;
                    m_state = (m_post == 0) ? 4 : 3;
                end
                if (se) m_wr++;
            end else if (m_state == 3 && se) begin
                m_wr++;
                m_rem--;
                if (m_rem == 0) m_state = 4;
            end
        end
    end

    initial begin : compare
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("state", st, m_state);
            chk("wr_ptr", wr, m_wr % 16);
            chk("trig_index", ti, m_ti % 16);
            chk("core_enabled", core_en, int'(m_state == 2 || m_state == 3));
            chk("core_rst_soft", core_rst, int'(m_state == 1));
            chk("trigger_out", trig_out, int'(m_trig));
            chk("done", done, int'(m_state == 4));
            chk("irq", irq, int'(m_state == 4 && m_last != 4));
            if (trig_out) n_trig++;
            if (irq) n_irq++;
            if (st == 3) n_post++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic samp(input logic [31:0] v, input logic x);
        sig = v; ext = x; se = 1;
        cyc(1);
        se = 0; ext = 0;
    endtask

    task automatic do_arm();
        arm = 1;
        cyc(1);
        arm = 0;
        chk("clear_rst_soft", core_rst, 1);
        chk("clear_wr_ptr", wr, 0);
        cyc(1);
        chk("armed_rst_soft", core_rst, 0);
        chk("armed_enabled", core_en, 1);
    endtask

    initial begin
        cyc(3);
        chk("rst_state", st, 0);
        chk("rst_wr_ptr", wr, 0);
        chk("rst_done", done, 0);
        chk("rst_enabled", core_en, 0);
        chk("rst_irq", irq, 0);
        rst = 1;
        cyc(1);

        mask = 32'hFF; value = 32'h5A; tedge = 0; post = 3;
        do_arm();
        post = 7;
        t0 = n_trig; i0 = n_irq;
        samp(32'h00, 0); samp(32'h11, 0); cyc(1); samp(32'h5A, 0);
        chk("t1_trig_pulse", trig_out, 1);
        samp(32'h01, 0);
        chk("t1_trig_once", trig_out, 0);
        samp(32'h02, 0); cyc(2); samp(32'h03, 0);
        chk("t1_done_state", st, 4);
        chk("t1_irq", irq, 1);
        samp(32'h04, 0); cyc(2);
        chk("t1_trig_index", ti, 2);
        chk("t1_wr_ptr", wr, 6);
        chk("t1_enabled", core_en, 0);
        chk("t1_done", done, 1);
        chk("t1_trig_pulses", n_trig - t0, 1);
        chk("t1_irq_pulses", n_irq - i0, 1);

        tedge = 1; mask = 32'h1; value = 32'h1; post = 2;
        do_arm();
        samp(1, 0);
        chk("t2_first_trig", ti, 0);
        samp(1, 0); samp(0, 0); samp(1, 0); cyc(1);
        chk("t2_trig_index", ti, 0);
        chk("t2_state", st, 4);
        chk("t2_wr_ptr", wr, 3);
        post = 0;
        arm = 1; cyc(1); arm = 0;
        sig = 1; se = 1; cyc(1); se = 0;
        chk("t2_clear_not_counted", wr, 0);
        samp(0, 0); samp(1, 0);
        chk("t2_rearm_state", st, 4);
        chk("t2_rearm_index", ti, 1);
        chk("t2_rearm_wr", wr, 2);

        tedge = 0; mask = 32'hFF; value = 32'hEE; post = 0;
        do_arm();
        p0 = n_post;
        repeat (4) samp(0, 0);
        samp(0, 1);
        chk("t3_done", st, 4);
        chk("t3_trig_index", ti, 4);
        chk("t3_wr_ptr", wr, 5);
        cyc(1);
        chk("t3_no_post", n_post - p0, 0);

        value = 32'h5A; post = 5;
        do_arm();
        i0 = n_irq;
        samp(0, 0); samp(32'h5A, 0); samp(1, 0);
        chk("t4_in_post", st, 3);
        abort = 1; arm = 1; sig = 32'h5A; se = 1;
        cyc(1);
        abort = 0; arm = 0; se = 0;
        chk("t4_abort_state", st, 0);
        chk("t4_abort_done", done, 0);
        chk("t4_abort_enabled", core_en, 0);
        chk("t4_abort_wr", wr, 3);
        cyc(3);
        chk("t4_no_irq", n_irq - i0, 0);
        do_arm();
        arm = 1; cyc(1); arm = 0;
        chk("t4_arm_ignored", st, 2);
        abort = 1; cyc(1); abort = 0;
        chk("t4_abort_armed", st, 0);

        mask = 32'hFF; value = 32'hAA; post = 1;
        do_arm();
        repeat (16) samp(0, 0);
        chk("t5_wrap", wr, 0);
        samp(0, 0); samp(0, 0); samp(32'hAA, 0);
        chk("t5_trig_index", ti, 2);
        samp(0, 0);
        chk("t5_done", st, 4);
        chk("t5_wr_ptr", wr, 4);
        mask = 0; post = 15;
        do_arm();
        samp(32'h1234, 0);
        chk("t5_mask0_index", ti, 0);
        chk("t5_mask0_post", st, 3);
        repeat (15) samp(0, 0);
        chk("t5_mask0_done", st, 4);
        chk("t5_mask0_wr", wr, 0);

`ifdef ILA_CAPTURE_HOLDOFF_EN
        mask = 32'hFF; value = 32'h5A; post = 0; pre = 5;
        do_arm();
        samp(0, 0); samp(0, 0); samp(32'h5A, 0);
        chk("t6_holdoff_ignored", st, 2);
        samp(0, 0); samp(0, 0); samp(32'h5A, 0);
        chk("t6_holdoff_done", st, 4);
        chk("t6_holdoff_index", ti, 5);
        pre = 0;
`endif

        mask = 32'hFF; value = 32'h5A; post = 2;
        do_arm();
        samp(0, 0); samp(32'h5A, 0); samp(0, 0);
        rst = 0;
        cyc(1);
        chk("rst_mid_state", st, 0);
        chk("rst_mid_wr", wr, 0);
        chk("rst_mid_index", ti, 0);
        chk("rst_mid_enabled", core_en, 0);
        chk("rst_mid_done", done, 0);
        rst = 1;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
